ex_mem_stage: RTL
=================

# ex_mem_stage

EX/MEM boundary stage of the pipelined RISC-V core. Captures the ALU result and execute-stage control for each instruction, resolves branches/jumps from the ALU's 1-bit compare result, and hands a registered record to the memory stage over a valid/ready handshake. Also issues the single-cycle PC redirect pulse to fetch and a flush request to the younger stages.

## Interface
- DATA_WIDTH, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_result  in  DATA_WIDTH  ALU output (compare ops produce 0/1).
- store_data  in  DATA_WIDTH  forwarded rs2 value.
- pc_plus4  in  DATA_WIDTH  return address for JAL/JALR.
- branch_target  in  DATA_WIDTH  PC+imm for branches and JAL.
- rd  in  REG_ADDR_W  destination register.
- funct3  in  3  load/store size, passed through.
- reg_write, mem_read, mem_write, mem_to_reg, branch, jal, jalr  in  1 each  decoded control.
- flush  in  1  discard all held entries (trap/external kill).
- out_valid  out  1  record available to memory stage.
- out_ready  in  1  memory stage accepts.
- out_result, out_store_data  out  DATA_WIDTH  write-back value, store data.
- out_rd, out_funct3, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  as inputs.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  DATA_WIDTH  new PC.

## Operation
- Accept when in_valid && in_ready; enqueue record in order.
- taken = jal | jalr | (branch & alu_result[0]).
- out_result = (jal|jalr) ? pc_plus4 : alu_result.
- redirect target: jalr ? (alu_result & ~1) : branch_target; bit 0 forced 0 in all cases.
- Taken accept: redirect_valid=1 next cycle for exactly one cycle, redirect_pc = target; the record is still enqueued (it writes rd for jumps).
- Branch records enqueued with reg_write/mem_write as given (decoder zeroes them); stage does not alter control bits.
- Output dequeues when out_valid && out_ready; out_* always reflect head entry, stable while out_valid && !out_ready.
- flush: all entries invalidated next edge; a same-cycle accept is dropped and generates no redirect; a redirect already high still completes its cycle.
- Reset: all entries invalid, out_valid=0, redirect_valid=0, all out_* data and redirect_pc = 0; in_ready=1 after reset deasserts.

## Timing
- Latency: accept in cycle N -> out_valid in N+1 (empty stage).
- redirect_valid asserted in N+1 for taken accept in N; independent of out_ready backpressure.
- Simultaneous enqueue and dequeue in one cycle keeps occupancy constant, order preserved.
- Reset asserted mid-operation clears everything immediately (asynchronous), including a pending redirect.
- alu_result[0] only is used for branch decision; upper bits ignored for branch records.

## Configuration
- EX_MEM_SKID_EN defined: 2-entry FIFO; in_ready = (occupancy < 2), a function of registers only (no combinational path out_ready -> in_ready); full throughput under continuous traffic, one bubble-free absorb on out_ready drop.
- Not defined: single entry; in_ready = !full | out_ready (combinational); same ordering, latency and redirect behaviour.

## Test plan
- Reset: rst_n=0 mid-transfer -> out_valid=0, redirect_valid=0, out_result=0 immediately; in_ready=1 after release.
- ADD: accept alu_result=0x0000_0007, rd=5, reg_write=1 -> next cycle out_valid=1, out_result=7, out_rd=5, redirect_valid=0.
- BEQ taken: branch=1, alu_result=1, branch_target=0x0000_0040 -> redirect_valid=1 for one cycle, redirect_pc=0x40; not-taken (alu_result=0) -> no pulse.
- JALR: alu_result=0x0000_1003, pc_plus4=0x0000_0104 -> redirect_pc=0x1002, out_result=0x104.
- Backpressure: out_ready=0 for 3 cycles with 3 offered records -> skid build holds 2 in order, in_ready=0 while full; non-skid build holds 1; release drains in order with no loss/duplication.
- Flush with same-cycle taken accept -> entries gone next cycle, out_valid=0, no redirect pulse.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline boundary of the RISC-V core.
//
// This stage registers the execute-stage result and control for each
// instruction. It resolves taken branches and jumps, then passes an
// in-order record to the memory stage. A taken accept raises a
// one-cycle PC redirect pulse on the following cycle.
//
// Build option EX_MEM_SKID_EN:
//   defined   -> 2-entry FIFO. in_ready depends only on registered
//                occupancy, so there is no combinational path from
//                out_ready to in_ready.
//   undefined -> single entry. in_ready = empty | out_ready, which is
//                combinational through out_ready.
//
// Handshake rules, used on both the input and the output side:
//   - A transfer happens on a rising edge where valid && ready.
//   - The producer holds valid and the payload steady until the
//     transfer happens.
//   - The consumer may change ready freely.
//   - out_* always shows the head entry. It stays stable while
//     out_valid && !out_ready.
module ex_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // execute-side handshake and payload
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] pc_plus4,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [2:0]            funct3,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  branch,
    input  logic                  jal,
    input  logic                  jalr,
    input  logic                  flush,
    // memory-side handshake and payload
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [2:0]            out_funct3,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    // fetch redirect
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

`ifdef EX_MEM_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    // Record handed to the memory stage. Control bits pass through unaltered.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } rec_t;

    // Two storage slots always exist.
    // In the single-entry build the pointers stay at 0, so slot 1 is
    // never written.
    rec_t                  r_mem [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic                  r_redirect_valid;
    logic [DATA_WIDTH-1:0] r_redirect_pc;

    logic                  w_accept;
    logic                  w_deq;
    logic                  w_taken;
    logic                  w_is_jump;
    logic [DATA_WIDTH-1:0] w_target_raw;
    logic [DATA_WIDTH-1:0] w_target;
    rec_t                  w_rec;
    rec_t                  w_head;

    // Pointer advance: toggles for the 2-entry FIFO, pinned to 0 for a single entry.
    function automatic logic adv_ptr(input logic p);
        return (DEPTH == 2) ? ~p : 1'b0;
    endfunction

`ifdef EX_MEM_SKID_EN
    // Ready depends only on occupancy, which breaks the out_ready -> in_ready path.
    assign in_ready = (r_count < 2'd2);
`else
    // A single slot can take new data in the same cycle it drains.
    assign in_ready = (r_count == 2'd0) || out_ready;
`endif

    assign out_valid = (r_count != 2'd0);
    assign w_deq     = out_valid && out_ready;
    // flush kills any accept in the same cycle, including its redirect.
    assign w_accept  = in_valid && in_ready && !flush;

    // Branch decision uses only alu_result[0]; jumps are always taken.
    assign w_is_jump    = jal | jalr;
    assign w_taken      = w_is_jump | (branch & alu_result[0]);
    assign w_target_raw = jalr ? alu_result : branch_target;
    assign w_target     = {w_target_raw[DATA_WIDTH-1:1], 1'b0};

    // Assemble the record; jumps write the link address back to rd.
    always_comb begin
        w_rec            = '0;
        w_rec.result     = w_is_jump ? pc_plus4 : alu_result;
        w_rec.store_data = store_data;
        w_rec.rd         = rd;
        w_rec.funct3     = funct3;
        w_rec.reg_write  = reg_write;
        w_rec.mem_read   = mem_read;
        w_rec.mem_write  = mem_write;
        w_rec.mem_to_reg = mem_to_reg;
    end

    // Storage, pointers and occupancy; flush empties the queue on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_rec;
                r_wr_ptr        <= adv_ptr(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= adv_ptr(r_rd_ptr);
            end
            case ({w_accept, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle redirect pulse after a taken accept; the target is held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept && w_taken;
            if (w_accept && w_taken) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    // Head-of-queue view presented to the memory stage.
    always_comb begin
        w_head = r_mem[r_rd_ptr];
    end

    assign out_result     = w_head.result;
    assign out_store_data = w_head.store_data;
    assign out_rd         = w_head.rd;
    assign out_funct3     = w_head.funct3;
    assign out_reg_write  = w_head.reg_write;
    assign out_mem_read   = w_head.mem_read;
    assign out_mem_write  = w_head.mem_write;
    assign out_mem_to_reg = w_head.mem_to_reg;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule
